mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 32-bit RISC-V pipeline; sits directly downstream of the execute stage and consumes its pipeline outputs: ALU result, instruction word, PC, writeback register/enable, store enable and store data.
- Performs loads and stores over a req/ack data-memory handshake, with byte-lane steering and sign/zero extension.
- Produces registered writeback-stage inputs and the MEM-stage forwarding tap.
- Stalls upstream while a memory access is outstanding.

Parameters:
- ADDR_W, 32, data-memory address width
- XLEN, 32, data width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  execute-stage outputs are a live instruction
- alu_in  in  32  ALU result; also the effective address for loads/stores
- iw_in  in  32  instruction word
- pc_in  in  32  instruction PC
- wb_reg_in  in  5  destination register
- wb_en_in  in  1  register writeback enable
- w_en_in  in  1  store indication from execute
- rs2_data_in  in  32  store data
- stall_out  out  1  upstream must hold its outputs
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  ADDR_W  word-aligned address ({alu[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-steered store data
- dmem_ack  in  1  memory completes the request this cycle
- dmem_rdata  in  32  read word, valid while dmem_ack=1
- valid_out  out  1  writeback outputs are live
- wb_data_out  out  32  load result or passed-through ALU result
- iw_out  out  32  registered iw
- pc_out  out  32  registered pc
- wb_reg_out  out  5  registered destination register
- wb_en_out  out  1  registered writeback enable
- misalign_err  out  1  one-cycle pulse on a misaligned or illegal access
- df_mem_enable  out  1  forwarding valid
- df_mem_reg  out  5  forwarding register
- df_mem_data  out  32  forwarding data

Behaviour:
- Reset: state=IDLE. All outputs 0, including dmem_req, valid_out, misalign_err and df_mem_*.
- Decode:
  - opcode 0000011 = load.
  - opcode 0100011 with w_en_in=1 = store.
  - Anything else is a non-memory op.
- IDLE, valid_in=1, non-memory op:
  - Next edge: valid_out=1, wb_data_out=alu_in; iw/pc/wb_reg/wb_en registered.
  - Latency 1 cycle; stall_out=0.
- IDLE, valid_in=1, memory op, aligned and legal:
  - Latch iw/pc/wb_reg/wb_en/funct3/addr[1:0].
  - Next edge: dmem_req=1 with addr/we/be/wdata; state=WAIT; valid_out=0.
- WAIT:
  - stall_out=1 every cycle in WAIT, including the ack cycle; valid_in is ignored.
  - dmem_req and all dmem_* outputs are held stable until dmem_ack.
  - On dmem_ack: next edge → dmem_req=0, state=IDLE, valid_out=1.
  - Load: wb_data_out = extracted rdata. Store: wb_en_out forced 0, wb_data_out=0.
  - Minimum memory-op occupancy is 2 cycles plus the ack wait. One bubble follows each memory op; this is intentional.
- Store steering (funct3):
  - SB: be = 1<<addr[1:0]; byte replicated across all lanes.
  - SH: be = 4'b0011 or 4'b1100 by addr[1]; halfword replicated.
  - SW: be = 4'b1111.
- Load extraction (funct3):
  - LB / LBU: byte lane addr[1:0], sign- or zero-extended.
  - LH / LHU: halfword lane addr[1], sign- or zero-extended.
  - LW: full word.
- Errors:
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
  - Illegal: load funct3 ∈ {011,110,111}; store funct3 ≥ 011.
  - Response: no dmem_req; misalign_err=1 for one cycle; valid_out=1 with wb_en_out=0; state stays IDLE.
- Forwarding: df_mem_enable = valid_out & wb_en_out & (wb_reg_out≠0); df_mem_reg = wb_reg_out; df_mem_data = wb_data_out. Registered with the outputs, no extra latency.
- dmem_ack in IDLE is ignored.
- Reset in WAIT: dmem_req drops at that edge, state=IDLE, and a subsequent late ack is ignored.
- valid_out deasserts the cycle after a completed op unless a new op completes.

Decomposition:
- riscv_pkg holds the shared constants: opcodes (LOAD, STORE, OP, JALR), load/store funct3 codes, and the state enum {IDLE, WAIT}.
- One sub-module, load_align: combinational extraction and extension from rdata, addr[1:0] and funct3. It is reused by later cache work.

Test Plan:
1. ADD, valid_in=1, alu_in=0x00001234, wb_reg_in=5, wb_en_in=1 → next cycle valid_out=1, wb_data_out=0x00001234, df_mem_enable=1, df_mem_reg=5, stall_out=0.
2. SB, alu_in=0x00000103, rs2=0x000000AB, ack delayed 3 cycles → dmem_addr=0x100, be=4'b1000, wdata=0xABABABAB, dmem_req held 4 cycles, stall_out high throughout WAIT, then valid_out=1, wb_en_out=0.
3. LB at 0x102, rdata=0x80FF7F00, immediate ack → wb_data_out=0xFFFFFFFF. LBU at the same address → 0x000000FF. LH at 0x102 → 0xFFFF80FF.
4. LH at 0x101 → misalign_err pulses 1 cycle, dmem_req stays 0, valid_out=1, wb_en_out=0, df_mem_enable=0.
5. LW issued, reset asserted in the second WAIT cycle, dmem_ack raised the following cycle → dmem_req=0 after the reset edge, all outputs 0, ack ignored, state IDLE.
6. LW to x0, ack with rdata=0xDEADBEEF → wb_data_out=0xDEADBEEF, df_mem_enable=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V memory stage.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic {IDLE, WAIT} mem_state_e;

  // Context of the memory op in flight, latched when the request is launched.
  typedef struct packed {
    logic [31:0] iw;
    logic [31:0] pc;
    logic [4:0]  wb_reg;
    logic        wb_en;
    logic        is_load;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
  } mem_ctx_t;

  // 1 when the access is misaligned or uses an unsupported width code.
  function automatic logic access_bad(input logic is_load, input logic [2:0] f3,
                                      input logic [1:0] lo);
    logic illegal;
    logic misal;
    if (is_load) illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    else         illegal = (f3 >= 3'b011);
    misal = ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    return illegal || misal;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data extraction: picks the byte/halfword lane and sign/zero-extends.
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

  // Extend the selected lane according to the load width code.
  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: launches loads/stores on a req/ack port, stalls the
// front of the pipe while waiting, and registers the writeback outputs.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [XLEN-1:0]   alu_in,
  input  logic [31:0]       iw_in,
  input  logic [31:0]       pc_in,
  input  logic [4:0]        wb_reg_in,
  input  logic              wb_en_in,
  input  logic              w_en_in,
  input  logic [XLEN-1:0]   rs2_data_in,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              valid_out,
  output logic [XLEN-1:0]   wb_data_out,
  output logic [31:0]       iw_out,
  output logic [31:0]       pc_out,
  output logic [4:0]        wb_reg_out,
  output logic              wb_en_out,
  output logic              misalign_err,
  output logic              df_mem_enable,
  output logic [4:0]        df_mem_reg,
  output logic [XLEN-1:0]   df_mem_data
);

  localparam int NUM_LANES = XLEN / 8;

  mem_state_e state, state_nx;
  mem_ctx_t   ctx;

  logic [6:0] opcode;
  logic [2:0] f3_in;
  logic       is_load_in, is_store_in, is_mem_in, bad_in;
  logic       start_ok, done;
  logic [XLEN-1:0] ld_data;

  logic [NUM_LANES-1:0]      lane_be;
  logic [NUM_LANES-1:0][7:0] lane_wd;

  assign opcode      = iw_in[6:0];
  assign f3_in       = iw_in[14:12];
  assign is_load_in  = (opcode == OPC_LOAD);
  assign is_store_in = (opcode == OPC_STORE) && w_en_in;
  assign is_mem_in   = is_load_in || is_store_in;
  assign bad_in      = access_bad(is_load_in, f3_in, alu_in[1:0]);
  assign start_ok    = (state == IDLE) && valid_in && is_mem_in && !bad_in;
  assign done        = (state == WAIT) && dmem_ack;

  // Per-lane store steering: narrow stores replicate their data on every
  // lane so the memory only has to honour the byte enables.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    assign lane_be[i] = (f3_in[1:0] == 2'b00) ? (alu_in[1:0] == LANE) :
                        (f3_in[1:0] == 2'b01) ? (alu_in[1] == LANE[1]) : 1'b1;
    assign lane_wd[i] = (f3_in[1:0] == 2'b00) ? rs2_data_in[7:0] :
                        (f3_in[1:0] == 2'b01) ? rs2_data_in[8*(i%2) +: 8] :
                                                rs2_data_in[8*i +: 8];
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (ctx.addr_lo),
    .funct3  (ctx.funct3),
    .data    (ld_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and stall: the whole WAIT residency holds the upstream stage.
  always_comb begin
    state_nx  = state;
    stall_out = 1'b0;
    case (state)
      IDLE: if (start_ok) state_nx = WAIT;
      WAIT: begin
        stall_out = 1'b1;
        if (dmem_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Memory request port; fields stay frozen from launch until the ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
    end else if (start_ok) begin
      dmem_req   <= 1'b1;
      dmem_we    <= is_store_in;
      dmem_addr  <= {alu_in[ADDR_W-1:2], 2'b00};
      dmem_be    <= is_store_in ? lane_be : 4'b1111;
      dmem_wdata <= is_store_in ? lane_wd : '0;
    end else if (done) begin
      dmem_req   <= 1'b0;
    end
  end

  // Latch the in-flight op context at launch.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctx <= '0;
    end else if (start_ok) begin
      ctx.iw      <= iw_in;
      ctx.pc      <= pc_in;
      ctx.wb_reg  <= wb_reg_in;
      ctx.wb_en   <= wb_en_in;
      ctx.is_load <= is_load_in;
      ctx.funct3  <= f3_in;
      ctx.addr_lo <= alu_in[1:0];
    end
  end

  // Writeback registers: completed memory op, pass-through op, or error.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out    <= 1'b0;
      wb_data_out  <= '0;
      iw_out       <= '0;
      pc_out       <= '0;
      wb_reg_out   <= '0;
      wb_en_out    <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      valid_out    <= 1'b0;
      misalign_err <= 1'b0;
      if (done) begin
        valid_out   <= 1'b1;
        iw_out      <= ctx.iw;
        pc_out      <= ctx.pc;
        wb_reg_out  <= ctx.wb_reg;
        wb_en_out   <= ctx.is_load & ctx.wb_en;
        wb_data_out <= ctx.is_load ? ld_data : '0;
      end else if ((state == IDLE) && valid_in && !start_ok) begin
        valid_out  <= 1'b1;
        iw_out     <= iw_in;
        pc_out     <= pc_in;
        wb_reg_out <= wb_reg_in;
        if (is_mem_in) begin
          misalign_err <= 1'b1;
          wb_en_out    <= 1'b0;
          wb_data_out  <= '0;
        end else begin
          wb_en_out    <= wb_en_in;
          wb_data_out  <= alu_in;
        end
      end
    end
  end

  assign df_mem_enable = valid_out & wb_en_out & (wb_reg_out != 5'd0);
  assign df_mem_reg    = wb_reg_out;
  assign df_mem_data   = wb_data_out;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a writeback scoreboard and monitor.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] alu_in, iw_in, pc_in, rs2_data_in;
  logic [4:0]  wb_reg_in;
  logic        wb_en_in, w_en_in;
  logic        stall_out, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        valid_out, wb_en_out, misalign_err, df_mem_enable;
  logic [31:0] wb_data_out, iw_out, pc_out, df_mem_data;
  logic [4:0]  wb_reg_out, df_mem_reg;

  mem_stage #(.ADDR_W(32), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .alu_in(alu_in), .iw_in(iw_in),
    .pc_in(pc_in), .wb_reg_in(wb_reg_in), .wb_en_in(wb_en_in), .w_en_in(w_en_in),
    .rs2_data_in(rs2_data_in), .stall_out(stall_out), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .valid_out(valid_out),
    .wb_data_out(wb_data_out), .iw_out(iw_out), .pc_out(pc_out), .wb_reg_out(wb_reg_out),
    .wb_en_out(wb_en_out), .misalign_err(misalign_err), .df_mem_enable(df_mem_enable),
    .df_mem_reg(df_mem_reg), .df_mem_data(df_mem_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        wb_en;
    logic [4:0]  rd;
    logic        err;
    logic        df_en;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int total = 0;
  int bad   = 0;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] AL = 7'b0110011;

  function automatic logic [31:0] mk_iw(input logic [6:0] op, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, op};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic en, input logic [4:0] rd,
                      input logic err, input logic df);
    exp_t e;
    e.data = d; e.wb_en = en; e.rd = rd; e.err = err; e.df_en = df;
    sb.push_back(e);
  endtask

  // Monitor: every live writeback output is matched against the scoreboard.
  always @(negedge clk) begin
    if (!reset && valid_out) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got data %h with no expected entry", wb_data_out);
      end else begin
        me = sb.pop_front();
        chk("wb_data", wb_data_out, me.data);
        chk("wb_en", 32'(wb_en_out), 32'(me.wb_en));
        chk("wb_reg", 32'(wb_reg_out), 32'(me.rd));
        chk("misalign", 32'(misalign_err), 32'(me.err));
        chk("df_en", 32'(df_mem_enable), 32'(me.df_en));
        chk("df_reg", 32'(df_mem_reg), 32'(me.rd));
        chk("df_data", df_mem_data, me.data);
      end
    end
  end

  // Present one instruction for one cycle; returns on the following negedge.
  task automatic drive(input logic [31:0] iw, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic wben, input logic st);
    valid_in = 1'b1; iw_in = iw; alu_in = alu; rs2_data_in = rs2;
    wb_reg_in = rd; wb_en_in = wben; w_en_in = st; pc_in = pc_in + 32'd4;
    @(negedge clk);
    valid_in = 1'b0; w_en_in = 1'b0;
  endtask

  // Issue a memory op, check the request, answer after dly idle cycles.
  task automatic mem_op(input string nm, input logic [31:0] iw, input logic [31:0] alu,
                        input logic [31:0] rs2, input logic [4:0] rd, input logic st,
                        input int dly, input logic [31:0] rdata, input logic [31:0] eaddr,
                        input logic [3:0] ebe, input logic [31:0] ewd);
    int hi;
    drive(iw, alu, rs2, rd, 1'b1, st);
    chk({nm, "_req"}, 32'(dmem_req), 32'd1);
    chk({nm, "_addr"}, dmem_addr, eaddr);
    chk({nm, "_we"}, 32'(dmem_we), 32'(st));
    if (st) begin
      chk({nm, "_be"}, 32'(dmem_be), 32'(ebe));
      chk({nm, "_wdata"}, dmem_wdata, ewd);
    end
    hi = 0;
    for (int k = 0; k < dly; k++) begin
      if (dmem_req && stall_out && dmem_addr == eaddr) hi++;
      @(negedge clk);
    end
    dmem_ack = 1'b1; dmem_rdata = rdata;
    if (dmem_req && stall_out && dmem_addr == eaddr) hi++;
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = $urandom;
    chk({nm, "_req_cycles"}, 32'(hi), 32'(dly + 1));
    chk({nm, "_req_drop"}, 32'(dmem_req), 32'd0);
    chk({nm, "_stall_after"}, 32'(stall_out), 32'd0);
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; alu_in = '0; iw_in = '0; pc_in = 32'h1000;
    rs2_data_in = '0; wb_reg_in = '0; wb_en_in = 1'b0; w_en_in = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_err", 32'(misalign_err), 32'd0);
    chk("rst_df", 32'(df_mem_enable), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_data", wb_data_out, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Pass-through ALU ops, back to back, then one to x0.
    push(32'h00001234, 1'b1, 5'd5, 1'b0, 1'b1);
    drive(mk_iw(AL, 3'b000), 32'h00001234, 32'd0, 5'd5, 1'b1, 1'b0);
    chk("add_stall", 32'(stall_out), 32'd0);
    push(32'h00000055, 1'b1, 5'd0, 1'b0, 1'b0);
    drive(mk_iw(AL, 3'b000), 32'h00000055, 32'd0, 5'd0, 1'b1, 1'b0);
    chk("add_valid_drop_pre", 32'(valid_out), 32'd1);
    @(negedge clk);
    chk("valid_deassert", 32'(valid_out), 32'd0);

    // Store opcode without w_en is a plain pass-through.
    push(32'h00000077, 1'b1, 5'd3, 1'b0, 1'b1);
    drive(mk_iw(ST, 3'b010), 32'h00000077, 32'h11111111, 5'd3, 1'b1, 1'b0);
    chk("st_noen_req", 32'(dmem_req), 32'd0);

    // Stores: SB with a 3-cycle ack delay, SH upper half, SW.
    push(32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    mem_op("sb", mk_iw(ST, 3'b000), 32'h00000103, 32'h000000AB, 5'd0, 1'b1, 3,
           32'd0, 32'h00000100, 4'b1000, 32'hABABABAB);
    push(32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    mem_op("sh", mk_iw(ST, 3'b001), 32'h00000102, 32'h1234CDEF, 5'd0, 1'b1, 0,
           32'd0, 32'h00000100, 4'b1100, 32'hCDEFCDEF);
    push(32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    mem_op("sw", mk_iw(ST, 3'b010), 32'h00000104, 32'h12345678, 5'd0, 1'b1, 1,
           32'd0, 32'h00000104, 4'b1111, 32'h12345678);

    // Loads from rdata 0x80FF7F00.
    push(32'hFFFFFFFF, 1'b1, 5'd7, 1'b0, 1'b1);
    mem_op("lb", mk_iw(LD, 3'b000), 32'h00000102, 32'd0, 5'd7, 1'b0, 0,
           32'h80FF7F00, 32'h00000100, 4'b0000, 32'd0);
    push(32'h000000FF, 1'b1, 5'd7, 1'b0, 1'b1);
    mem_op("lbu", mk_iw(LD, 3'b100), 32'h00000102, 32'd0, 5'd7, 1'b0, 0,
           32'h80FF7F00, 32'h00000100, 4'b0000, 32'd0);
    push(32'hFFFF80FF, 1'b1, 5'd8, 1'b0, 1'b1);
    mem_op("lh", mk_iw(LD, 3'b001), 32'h00000102, 32'd0, 5'd8, 1'b0, 0,
           32'h80FF7F00, 32'h00000100, 4'b0000, 32'd0);
    push(32'h00007F00, 1'b1, 5'd8, 1'b0, 1'b1);
    mem_op("lhu", mk_iw(LD, 3'b101), 32'h00000100, 32'd0, 5'd8, 1'b0, 2,
           32'h80FF7F00, 32'h00000100, 4'b0000, 32'd0);
    push(32'h0000007F, 1'b1, 5'd9, 1'b0, 1'b1);
    mem_op("lb1", mk_iw(LD, 3'b000), 32'h00000101, 32'd0, 5'd9, 1'b0, 0,
           32'h80FF7F00, 32'h00000100, 4'b0000, 32'd0);

    // Misaligned / illegal accesses.
    push(32'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    drive(mk_iw(LD, 3'b001), 32'h00000101, 32'd0, 5'd9, 1'b1, 1'b0);
    chk("lh_mis_req", 32'(dmem_req), 32'd0);
    chk("lh_mis_stall", 32'(stall_out), 32'd0);
    @(negedge clk);
    chk("mis_pulse_end", 32'(misalign_err), 32'd0);
    chk("mis_valid_end", 32'(valid_out), 32'd0);
    push(32'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    drive(mk_iw(LD, 3'b010), 32'h00000102, 32'd0, 5'd4, 1'b1, 1'b0);
    chk("lw_mis_req", 32'(dmem_req), 32'd0);
    push(32'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    drive(mk_iw(LD, 3'b111), 32'h00000100, 32'd0, 5'd4, 1'b1, 1'b0);
    push(32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    drive(mk_iw(ST, 3'b011), 32'h00000100, 32'h5A5A5A5A, 5'd0, 1'b0, 1'b1);
    chk("st_ill_req", 32'(dmem_req), 32'd0);

    // Ack while idle is ignored.
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("idle_ack_req", 32'(dmem_req), 32'd0);
    chk("idle_ack_valid", 32'(valid_out), 32'd0);

    // Reset during WAIT, then a late ack.
    drive(mk_iw(LD, 3'b010), 32'h00000200, 32'd0, 5'd6, 1'b1, 1'b0);
    chk("rw_req_up", 32'(dmem_req), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    chk("rw_req_drop", 32'(dmem_req), 32'd0);
    chk("rw_valid", 32'(valid_out), 32'd0);
    chk("rw_stall", 32'(stall_out), 32'd0);
    chk("rw_data", wb_data_out, 32'd0);
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("rw_late_req", 32'(dmem_req), 32'd0);
    chk("rw_late_valid", 32'(valid_out), 32'd0);
    chk("rw_late_stall", 32'(stall_out), 32'd0);

    // LW to x0: data written through, no forwarding.
    push(32'hDEADBEEF, 1'b1, 5'd0, 1'b0, 1'b0);
    mem_op("lw_x0", mk_iw(LD, 3'b010), 32'h00000300, 32'd0, 5'd0, 1'b0, 0,
           32'hDEADBEEF, 32'h00000300, 4'b0000, 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
